// File: rtl/led_bar_pkg.sv
// Shared types and helpers for the LED bar monitor.
// Holds bar width, level type, FSM states and thermometer decode helpers.
package led_bar_pkg;

    localparam int WIDTH = 8;

    typedef logic [3:0] level_t;

    typedef enum logic {
        SYNC_WAIT,
        LOCKED
    } state_t;

    // Legal fill is 2^k-1: adding one clears every set bit.
    function automatic logic is_thermo(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] xp;
        xp = x + WIDTH'(1);
        return (x & xp) == '0;
    endfunction

    function automatic level_t thermo_level(input logic [WIDTH-1:0] x);
        level_t n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + level_t'(x[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/led_bar_monitor_thermo_decode.sv
// Combinational thermometer decoder.
// Ports: pat (bar pattern) -> legal (is 2^k-1), level (popcount k).
module thermo_decode
    import led_bar_pkg::*;
(
    input  logic [WIDTH-1:0] pat,
    output logic             legal,
    output level_t           level
);

    assign legal = is_thermo(pat);
    assign level = thermo_level(pat);

endmodule

// File: rtl/led_bar_monitor.sv
// Receive-side checker for the thermometer LED bar fill sequence.
// Ports: clk, reset (sync, active-low), bar_in, clr_err in;
// level, level_valid, locked, pattern_err, seq_err, timing_err,
// step_count out (all registered).
module led_bar_monitor
    import led_bar_pkg::*;
#(
    parameter int WIDTH      = led_bar_pkg::WIDTH,
    parameter int EXP_PERIOD = 50_000_001,
    parameter int TOL        = 1000,
    parameter int CNT_W      = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bar_in,
    input  logic             clr_err,
    output logic [3:0]       level,
    output logic             level_valid,
    output logic             locked,
    output logic             pattern_err,
    output logic             seq_err,
    output logic             timing_err,
    output logic [15:0]      step_count
);

    localparam logic [CNT_W-1:0] GAP_LO  = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] GAP_HI  = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(EXP_PERIOD + TOL + 1);

    state_t           state, state_d;
    logic [WIDTH-1:0] bar_q, prev, prev_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    level_t           level_d, nxt, k;
    logic             valid_d, pat_d, seq_d, tim_d;
    logic [15:0]      step_d;
    logic             legal, change, in_lock;

    thermo_decode u_dec (
        .pat   (bar_q),
        .legal (legal),
        .level (k)
    );

    assign change  = bar_q != prev;
    assign in_lock = state == LOCKED;
    // After a full bar the fill restarts at one lit segment.
    assign nxt     = (level == level_t'(8)) ? level_t'(1)
                                            : level + level_t'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= SYNC_WAIT;
            bar_q       <= '0;
            prev        <= '0;
            cnt         <= '0;
            level       <= '0;
            level_valid <= 1'b0;
            locked      <= 1'b0;
            pattern_err <= 1'b0;
            seq_err     <= 1'b0;
            timing_err  <= 1'b0;
            step_count  <= '0;
        end else begin
            state       <= state_d;
            bar_q       <= bar_in;
            prev        <= prev_d;
            cnt         <= cnt_d;
            level       <= level_d;
            level_valid <= valid_d;
            locked      <= state_d == LOCKED;
            pattern_err <= pat_d;
            seq_err     <= seq_d;
            timing_err  <= tim_d;
            step_count  <= step_d;
        end
    end

    always_comb begin
        state_d = state;
        prev_d  = prev;
        level_d = level;
        valid_d = 1'b0;
        step_d  = step_count;
        // New errors below override a simultaneous clear.
        pat_d   = pattern_err & ~clr_err;
        seq_d   = seq_err & ~clr_err;
        tim_d   = timing_err & ~clr_err;
        cnt_d   = (cnt == GAP_MAX) ? cnt : cnt + CNT_W'(1);
        if (change) begin
            prev_d = bar_q;
            cnt_d  = CNT_W'(1);
            if (in_lock && (cnt < GAP_LO || cnt > GAP_HI)) begin
                tim_d = 1'b1;
            end
            unique case (1'b1)
                !legal: begin
                    pat_d   = 1'b1;
                    state_d = SYNC_WAIT;
                end
                legal && !in_lock: begin
                    level_d = k;
                    valid_d = 1'b1;
                    if (bar_q == WIDTH'(1)) begin
                        state_d = LOCKED;
                    end
                end
                legal && in_lock && k == nxt: begin
                    level_d = k;
                    valid_d = 1'b1;
                    step_d  = step_count + 16'd1;
                end
                default: begin
                    level_d = k;
                    valid_d = 1'b1;
                    seq_d   = 1'b1;
                    state_d = SYNC_WAIT;
                end
            endcase
        end else if (in_lock && cnt == GAP_MAX - CNT_W'(1)) begin
            // Counter is about to saturate: the generator has stalled.
            tim_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_led_bar_monitor.sv
// Self-checking bench for led_bar_monitor (EXP_PERIOD=10, TOL=1).
// Directed and random bar sequences checked against a behavioural model.
module tb_led_bar_monitor;

    localparam int EXP = 10;
    localparam int TOL = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  bar_in = 8'h00;
    logic        clr_err = 1'b0;
    logic [3:0]  level;
    logic        level_valid;
    logic        locked;
    logic        pattern_err;
    logic        seq_err;
    logic        timing_err;
    logic [15:0] step_count;

    int ncomp = 0;
    int nfail = 0;
    int cyc = 0;

    // Behavioural model state.
    logic [7:0] mprev;
    int         mlevel;
    int         mstep;
    bit         mlocked, mvalid, mpat, mseq, mtim, stall_done;
    int         last_det;

    led_bar_monitor #(
        .WIDTH      (8),
        .EXP_PERIOD (EXP),
        .TOL        (TOL),
        .CNT_W      (27)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bar_in      (bar_in),
        .clr_err     (clr_err),
        .level       (level),
        .level_valid (level_valid),
        .locked      (locked),
        .pattern_err (pattern_err),
        .seq_err     (seq_err),
        .timing_err  (timing_err),
        .step_count  (step_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fill level of a pattern, or -1 if it is not 2^k-1.
    function automatic int lvl_of(input logic [7:0] p);
        int v;
        v = int'(p) + 1;
        for (int i = 0; i <= 8; i++) begin
            if (v == (1 << i)) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] pat_of(input int k);
        int v;
        v = (1 << k) - 1;
        return v[7:0];
    endfunction

    task automatic apply_stall(input int upto);
        if (mlocked && !stall_done && upto >= last_det + EXP + TOL) begin
            mtim = 1;
            stall_done = 1;
        end
    endtask

    task automatic model_change(input logic [7:0] p, input int now);
        int  k, g, nx;
        bit  was;
        apply_stall(now - 1);
        if (p == mprev) return;
        k = lvl_of(p);
        g = now - last_det;
        was = mlocked;
        nx = (mlevel == 8) ? 1 : mlevel + 1;
        if (was && (g < EXP - TOL || g > EXP + TOL)) mtim = 1;
        if (k < 0) begin
            mpat = 1;
            mlocked = 0;
        end else begin
            mlevel = k;
            mvalid = 1;
            if (!was) begin
                if (p == 8'h01) mlocked = 1;
            end else if (k == nx) begin
                mstep = (mstep + 1) % 65536;
            end else begin
                mseq = 1;
                mlocked = 0;
            end
        end
        mprev = p;
        last_det = now;
        stall_done = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(mlevel));
        chk({tag, ".valid"}, 32'(level_valid), 32'(mvalid));
        chk({tag, ".locked"}, 32'(locked), 32'(mlocked));
        chk({tag, ".pat"}, 32'(pattern_err), 32'(mpat));
        chk({tag, ".seq"}, 32'(seq_err), 32'(mseq));
        chk({tag, ".tim"}, 32'(timing_err), 32'(mtim));
        chk({tag, ".steps"}, 32'(step_count), 32'(mstep));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bar_in = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mprev = 0; mlevel = 0; mstep = 0;
        mlocked = 0; mvalid = 0; mpat = 0; mseq = 0; mtim = 0;
        stall_done = 0;
        last_det = cyc;
        check_all("reset");
    endtask

    // Drive p, check after detection, hold g cycles total.
    task automatic step(input logic [7:0] p, input int g);
        bar_in = p;
        repeat (2) @(posedge clk);
        #1;
        model_change(p, cyc);
        check_all("chg");
        mvalid = 0;
        repeat (g - 2) @(posedge clk);
        #1;
        apply_stall(cyc);
        check_all("hold");
    endtask

    task automatic clear();
        int ce;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        ce = cyc;
        apply_stall(ce - 1);
        mpat = 0; mseq = 0; mtim = 0;
        apply_stall(ce);
        check_all("clr");
    endtask

    initial begin
        logic [7:0] p;
        int         r, g;

        do_reset();

        // Idle at 00: nothing happens.
        repeat (20) @(posedge clk);
        #1;
        check_all("idle");

        // Clean fill 01..FF then 01.
        for (int k = 1; k <= 8; k++) step(pat_of(k), 10);
        step(8'h01, 10);
        chk("fill.steps8", 32'(step_count), 32'd8);
        chk("fill.locked", 32'(locked), 32'd1);
        chk("fill.noerr", 32'({pattern_err, seq_err, timing_err}), 32'd0);

        // Gap edges: 10, 9, 11 fine; 8 and 12 flagged but counted.
        step(8'h03, 9);
        step(8'h07, 11);
        step(8'h0F, 8);
        chk("gap.ok", 32'(timing_err), 32'd0);
        step(8'h1F, 12);
        chk("gap8.err", 32'(timing_err), 32'd1);
        clear();
        step(8'h3F, 10);
        chk("gap12.err", 32'(timing_err), 32'd1);
        chk("gap12.steps", 32'(step_count), 32'd13);
        clear();

        // Stall at 07.
        step(8'h7F, 10);
        step(8'hFF, 10);
        step(8'h01, 10);
        step(8'h03, 10);
        step(8'h07, 14);
        chk("stall.err", 32'(timing_err), 32'd1);
        clear();
        repeat (15) @(posedge clk);
        #1;
        apply_stall(cyc);
        check_all("stall.sat");
        chk("stall.nore", 32'(timing_err), 32'd0);
        step(8'h0F, 10);
        clear();

        // Illegal pattern, then illegal sequence, then relock.
        step(8'h05, 10);
        chk("bad.pat", 32'(pattern_err), 32'd1);
        chk("bad.unlock", 32'(locked), 32'd0);
        step(8'h01, 10);
        step(8'h03, 10);
        step(8'h07, 10);
        step(8'h3F, 10);
        chk("seq.err", 32'(seq_err), 32'd1);
        chk("seq.level", 32'(level), 32'd6);
        step(8'h01, 10);
        chk("relock", 32'(locked), 32'd1);
        clear();

        // Random mix against the model.
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                p = 8'($urandom_range(0, 255));
            end else if (mlocked) begin
                p = pat_of((mlevel == 8) ? 1 : mlevel + 1);
            end else begin
                p = 8'h01;
            end
            if (p == mprev) p = (mprev == 8'h03) ? 8'h07 : 8'h03;
            g = (r == 9) ? $urandom_range(3, 20) : $urandom_range(8, 13);
            step(p, g);
            if (r == 1) clear();
        end

        // Reset mid-run at level 5 with a flag set.
        do_reset();
        step(8'h01, 10);
        step(8'h03, 8);
        step(8'h07, 10);
        step(8'h0F, 10);
        step(8'h1F, 10);
        chk("pre.level5", 32'(level), 32'd5);
        chk("pre.tim", 32'(timing_err), 32'd1);
        do_reset();
        chk("rst.level", 32'(level), 32'd0);
        chk("rst.flags", 32'({pattern_err, seq_err, timing_err}), 32'd0);
        chk("rst.locked", 32'(locked), 32'd0);
        step(8'h01, 10);
        chk("rst.relock", 32'(locked), 32'd1);
        chk("rst.steps", 32'(step_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncomp, nfail);
        $finish;
    end

endmodule
